// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared privilege/state types and interrupt priority ranking for trap_router
package trap_pkg;

  typedef enum logic [1:0] {
    PRV_U = 2'b00,
    PRV_S = 2'b01,
    PRV_M = 2'b11
  } priv_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESOLVE,
    ST_ISSUE
  } state_e;

  localparam int STD_IRQ_N = 6;
  localparam int STD_IRQ_ORDER [STD_IRQ_N] = '{11, 3, 7, 9, 1, 5};

  // Larger rank wins; standard causes outrank platform lines 12+, 0 means never taken.
  function automatic int irq_rank(input int idx);
    for (int k = 0; k < STD_IRQ_N; k++) begin
      if (STD_IRQ_ORDER[k] == idx) return 131072 - k;
    end
    if (idx >= 12) return 65536 - idx;
    return 0;
  endfunction

endpackage

// File: rtl/trap_router_irq_select.sv
// rtl/trap_router_irq_select.sv - combinational pick of the highest-priority takeable interrupt
module irq_select
  import trap_pkg::*;
#(
  parameter int NUM_IRQ = 16,
  parameter int CAUSE_W = 5
) (
  input  logic [NUM_IRQ-1:0] mip,
  input  logic [NUM_IRQ-1:0] mie,
  input  logic [NUM_IRQ-1:0] mideleg,
  input  logic [1:0]         priv,
  input  logic               mstatus_mie,
  input  logic               mstatus_sie,
  output logic               irq_any,
  output logic [CAUSE_W-1:0] irq_cause,
  output priv_e              irq_target
);

  logic               m_ok;
  logic               s_ok;
  logic [NUM_IRQ-1:0] takeable;
  int                 best;

  assign m_ok = (priv != PRV_M) || mstatus_mie;
  // Delegated interrupts can never preempt M-mode.
  assign s_ok = (priv == PRV_U) || ((priv == PRV_S) && mstatus_sie);
  assign takeable = mip & mie & ((mideleg & {NUM_IRQ{s_ok}}) | (~mideleg & {NUM_IRQ{m_ok}}));

  always_comb begin
    irq_any    = 1'b0;
    irq_cause  = '0;
    irq_target = PRV_M;
    best       = 0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (takeable[i] && (irq_rank(i) > best)) begin
        best       = irq_rank(i);
        irq_any    = 1'b1;
        irq_cause  = CAUSE_W'(i);
        irq_target = mideleg[i] ? PRV_S : PRV_M;
      end
    end
  end

endmodule

// File: rtl/trap_router.sv
// rtl/trap_router.sv - trap entry: exception/interrupt arbitration, delegation, vector and redirect hold
// Vectored-mode handler offset is built only with TRAP_ROUTER_VECTORED_EN defined.
module trap_router
  import trap_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5,
  parameter int NUM_IRQ = 16
) (
  input  logic                  cpu_clock_i,
  input  logic                  cpu_reset_i,
  input  logic                  trap_valid_i,
  output logic                  trap_ready_o,
  input  logic [CAUSE_W-1:0]    trap_cause_i,
  input  logic [XLEN-1:0]       trap_pc_i,
  input  logic [XLEN-1:0]       trap_tval_i,
  input  logic                  boundary_i,
  input  logic [XLEN-1:0]       boundary_pc_i,
  input  logic [1:0]            priv_i,
  input  logic                  mstatus_mie_i,
  input  logic                  mstatus_sie_i,
  input  logic [2**CAUSE_W-1:0] medeleg_i,
  input  logic [NUM_IRQ-1:0]    mideleg_i,
  input  logic [NUM_IRQ-1:0]    mip_i,
  input  logic [NUM_IRQ-1:0]    mie_i,
  input  logic [XLEN-1:0]       mtvec_i,
  input  logic [XLEN-1:0]       stvec_i,
  output logic                  redir_valid_o,
  input  logic                  redir_ack_i,
  output logic [XLEN-1:0]       redir_pc_o,
  output logic [1:0]            redir_priv_o,
  output logic [CAUSE_W-1:0]    redir_cause_o,
  output logic                  redir_irq_o,
  output logic [XLEN-1:0]       redir_epc_o,
  output logic [XLEN-1:0]       redir_tval_o
);

  state_e               state_q, state_d;
  logic                 irq_any;
  logic [CAUSE_W-1:0]   irq_cause;
  priv_e                irq_target;
  logic                 take_irq, take_exc, accept;

  logic [CAUSE_W-1:0]   cause_q;
  logic [XLEN-1:0]      epc_q, tval_q, mtvec_q, stvec_q, pc_q;
  logic                 irq_q, deleg_q;
  logic [1:0]           priv_q, tpriv_q;

  priv_e                tgt;
  logic [XLEN-1:0]      tvec, base, handler;

  irq_select #(
    .NUM_IRQ (NUM_IRQ),
    .CAUSE_W (CAUSE_W)
  ) u_irq_select (
    .mip         (mip_i),
    .mie         (mie_i),
    .mideleg     (mideleg_i),
    .priv        (priv_i),
    .mstatus_mie (mstatus_mie_i),
    .mstatus_sie (mstatus_sie_i),
    .irq_any     (irq_any),
    .irq_cause   (irq_cause),
    .irq_target  (irq_target)
  );

  // A takeable interrupt at a boundary steals the cycle; the exception simply waits.
  assign take_irq = (state_q == ST_IDLE) && boundary_i && irq_any;
  assign take_exc = (state_q == ST_IDLE) && !take_irq && trap_valid_i;
  assign accept   = take_irq || take_exc;

  assign trap_ready_o = (state_q == ST_IDLE);

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_RESOLVE;
      ST_RESOLVE: state_d = ST_ISSUE;
      ST_ISSUE:   if (redir_ack_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tgt  = (deleg_q && (priv_q != PRV_M)) ? PRV_S : PRV_M;
    tvec = (tgt == PRV_S) ? stvec_q : mtvec_q;
    base = tvec & ~XLEN'(3);
`ifdef TRAP_ROUTER_VECTORED_EN
    handler = (irq_q && tvec[0]) ? base + (XLEN'(cause_q) << 2) : base;
`else
    handler = base;
`endif
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
      irq_q   <= 1'b0;
      deleg_q <= 1'b0;
      priv_q  <= '0;
      mtvec_q <= '0;
      stvec_q <= '0;
      pc_q    <= '0;
      tpriv_q <= '0;
    end else begin
      if (accept) begin
        if (take_irq) begin
          cause_q <= irq_cause;
          epc_q   <= boundary_pc_i;
          tval_q  <= '0;
          irq_q   <= 1'b1;
          deleg_q <= (irq_target == PRV_S);
        end else begin
          cause_q <= trap_cause_i;
          epc_q   <= trap_pc_i;
          tval_q  <= trap_tval_i;
          irq_q   <= 1'b0;
          deleg_q <= medeleg_i[trap_cause_i];
        end
        priv_q  <= priv_i;
        mtvec_q <= mtvec_i;
        stvec_q <= stvec_i;
      end
      if (state_q == ST_RESOLVE) begin
        pc_q    <= handler;
        tpriv_q <= tgt;
      end
    end
  end

  assign redir_valid_o = (state_q == ST_ISSUE);
  assign redir_pc_o    = pc_q;
  assign redir_priv_o  = tpriv_q;
  assign redir_cause_o = cause_q;
  assign redir_irq_o   = irq_q;
  assign redir_epc_o   = epc_q;
  assign redir_tval_o  = tval_q;

endmodule

// File: tb/tb_trap_router.sv
// tb/tb_trap_router.sv - randomized scoreboard bench for trap_router against a rule-level model
module tb_trap_router;

  localparam int XLEN = 32, CAUSE_W = 5, NUM_IRQ = 16;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  priv;
    logic [4:0]  cause;
    logic        irq;
    logic [31:0] epc;
    logic [31:0] tval;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid, trap_ready;
  logic [4:0]  trap_cause;
  logic [31:0] trap_pc, trap_tval;
  logic        boundary;
  logic [31:0] boundary_pc;
  logic [1:0]  priv;
  logic        mstatus_mie, mstatus_sie;
  logic [31:0] medeleg;
  logic [15:0] mideleg, mip, mie;
  logic [31:0] mtvec, stvec;
  logic        redir_valid, redir_ack;
  logic [31:0] redir_pc;
  logic [1:0]  redir_priv;
  logic [4:0]  redir_cause;
  logic        redir_irq;
  logic [31:0] redir_epc, redir_tval;

  exp_t sc_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  trap_router #(.XLEN(XLEN), .CAUSE_W(CAUSE_W), .NUM_IRQ(NUM_IRQ)) dut (
    .cpu_clock_i   (clk),
    .cpu_reset_i   (rst),
    .trap_valid_i  (trap_valid),
    .trap_ready_o  (trap_ready),
    .trap_cause_i  (trap_cause),
    .trap_pc_i     (trap_pc),
    .trap_tval_i   (trap_tval),
    .boundary_i    (boundary),
    .boundary_pc_i (boundary_pc),
    .priv_i        (priv),
    .mstatus_mie_i (mstatus_mie),
    .mstatus_sie_i (mstatus_sie),
    .medeleg_i     (medeleg),
    .mideleg_i     (mideleg),
    .mip_i         (mip),
    .mie_i         (mie),
    .mtvec_i       (mtvec),
    .stvec_i       (stvec),
    .redir_valid_o (redir_valid),
    .redir_ack_i   (redir_ack),
    .redir_pc_o    (redir_pc),
    .redir_priv_o  (redir_priv),
    .redir_cause_o (redir_cause),
    .redir_irq_o   (redir_irq),
    .redir_epc_o   (redir_epc),
    .redir_tval_o  (redir_tval)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void model_irq(output bit found, output int cause, output logic [1:0] tgt);
    int order[$];
    int b;
    order = '{11, 3, 7, 9, 1, 5};
    for (int i = 12; i < NUM_IRQ; i++) order.push_back(i);
    found = 0; cause = 0; tgt = 2'b11;
    foreach (order[k]) begin
      b = order[k];
      if (!found && mip[b] && mie[b]) begin
        if (mideleg[b]) begin
          if (priv == 2'b00 || (priv == 2'b01 && mstatus_sie)) begin
            found = 1; cause = b; tgt = 2'b01;
          end
        end else if (priv != 2'b11 || mstatus_mie) begin
          found = 1; cause = b; tgt = 2'b11;
        end
      end
    end
  endfunction

  function automatic logic [31:0] model_vec(input logic [31:0] tvec, input bit irq, input int cause);
    longint unsigned h;
    h = tvec;
    h = h - (h % 4);
`ifdef TRAP_ROUTER_VECTORED_EN
    if (irq && tvec[0]) h = h + 4 * cause;
`endif
    return h[31:0];
  endfunction

  task automatic randomize_inputs();
    trap_valid  = 1'($urandom);
    boundary    = 1'($urandom);
    trap_cause  = 5'($urandom);
    trap_pc     = $urandom;
    trap_tval   = $urandom;
    boundary_pc = $urandom;
    case ($urandom_range(2))
      0: priv = 2'b00;
      1: priv = 2'b01;
      default: priv = 2'b11;
    endcase
    mstatus_mie = 1'($urandom);
    mstatus_sie = 1'($urandom);
    medeleg     = $urandom;
    mideleg     = 16'($urandom);
    mip         = 16'($urandom) & 16'($urandom);
    mie         = 16'($urandom) | 16'($urandom);
    mtvec       = $urandom;
    stvec       = $urandom;
  endtask

  task automatic chk_reset(input string name);
    check({name, "_valid"}, redir_valid, 0);
    check({name, "_ready"}, trap_ready, 1);
    check({name, "_pc"}, redir_pc, 0);
    check({name, "_priv"}, redir_priv, 0);
    check({name, "_cause"}, redir_cause, 0);
    check({name, "_irq"}, redir_irq, 0);
    check({name, "_epc"}, redir_epc, 0);
    check({name, "_tval"}, redir_tval, 0);
  endtask

  // Called just after a negedge with inputs set; returns after the accept edge.
  task automatic issue(output bit acc);
    exp_t e;
    bit f;
    int c;
    logic [1:0] t;
    model_irq(f, c, t);
    acc = 0;
    check("ready_before_accept", trap_ready, 1);
    if (f && boundary) begin
      e.irq = 1; e.cause = 5'(c); e.priv = t; e.epc = boundary_pc; e.tval = 0;
      e.pc = model_vec((t == 2'b01) ? stvec : mtvec, 1, c);
      acc = 1;
    end else if (trap_valid) begin
      e.irq = 0; e.cause = trap_cause;
      e.priv = (medeleg[trap_cause] && priv != 2'b11) ? 2'b01 : 2'b11;
      e.epc = trap_pc; e.tval = trap_tval;
      e.pc = model_vec((e.priv == 2'b01) ? stvec : mtvec, 0, trap_cause);
      acc = 1;
    end
    if (acc) begin
      e.cyc = cyc;
      sc_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic serve(input int hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!redir_valid && n < 6) begin
      n++;
      @(negedge clk);
    end
    if (!redir_valid) begin
      total++; bad++;
      $display("FAIL redirect_timeout: got valid=0 want valid=1");
      trap_valid = 0; boundary = 0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      randomize_inputs();
      @(negedge clk);
    end
    redir_ack = 1; trap_valid = 0; boundary = 0;
    @(negedge clk);
    redir_ack = 0;
    check("ready_after_ack", trap_ready, 1);
    check("valid_after_ack", redir_valid, 0);
  endtask

  task automatic run(input int hold);
    bit acc;
    issue(acc);
    if (acc) serve(hold);
    else begin
      repeat (2) begin
        @(negedge clk);
        check("idle_valid", redir_valid, 0);
        check("idle_ready", trap_ready, 1);
      end
    end
  endtask

  // Monitor: pops on the first redirect cycle, then demands stability while held.
  initial begin
    exp_t cur;
    bit active;
    active = 0;
    forever begin
      @(negedge clk);
      if (redir_valid) begin
        if (!active) begin
          if (sc_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_redirect: got cause %h want no redirect", redir_cause);
          end else begin
            cur = sc_q.pop_front();
            active = 1;
            check("latency", cyc, cur.cyc + 2);
          end
        end
        if (active) begin
          check("pc", redir_pc, cur.pc);
          check("priv", redir_priv, cur.priv);
          check("cause", redir_cause, cur.cause);
          check("irq", redir_irq, cur.irq);
          check("epc", redir_epc, cur.epc);
          check("tval", redir_tval, cur.tval);
          check("ready_in_issue", trap_ready, 0);
        end
      end else begin
        active = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    rst = 1; redir_ack = 0; trap_valid = 0; boundary = 0; trap_cause = 0;
    trap_pc = 0; trap_tval = 0; boundary_pc = 0; priv = 0; mstatus_mie = 0;
    mstatus_sie = 0; medeleg = 0; mideleg = 0; mip = 0; mie = 0; mtvec = 0; stvec = 0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 0;

    // delegated illegal instruction from U
    stvec = 32'h0000_4003; mtvec = 32'h8000_0001;
    priv = 2'b00; medeleg = 32'h4; trap_cause = 5'd2; trap_pc = 32'h100;
    trap_tval = 32'hdead_beef; trap_valid = 1;
    run(0);
    // same cause at M is never delegated
    priv = 2'b11; trap_valid = 1;
    run(1);
    // interrupt 11 beats 7 and the concurrent exception
    mip = 16'h0880; mie = 16'h0880; mideleg = 0; priv = 2'b11; mstatus_mie = 1;
    boundary = 1; boundary_pc = 32'h200; trap_valid = 1;
    run(0);
    // delegated STI gated by sie, never at M
    mip = 16'h0020; mie = 16'h0020; mideleg = 16'h0020; priv = 2'b01;
    mstatus_sie = 0; mstatus_mie = 0; boundary = 1; trap_valid = 0;
    run(0);
    mstatus_sie = 1;
    run(0);
    priv = 2'b11; mstatus_mie = 1; boundary = 1;
    run(0);
    // long hold with inputs churning
    mip = 0; priv = 2'b01; medeleg = 32'h0; trap_cause = 5'd13; trap_pc = 32'h3000;
    trap_valid = 1; boundary = 0;
    run(10);

    // reset while resolving
    trap_valid = 1; boundary = 0; mip = 0;
    issue(acc);
    @(negedge clk);
    check("resolve_valid_low", redir_valid, 0);
    rst = 1; trap_valid = 0;
    if (acc) sc_q.delete(sc_q.size() - 1);
    @(negedge clk);
    chk_reset("rst_resolve");
    rst = 0;
    // reset while issuing
    trap_valid = 1;
    issue(acc);
    @(negedge clk);
    @(negedge clk);
    check("issue_valid_high", redir_valid, 1);
    rst = 1; trap_valid = 0;
    @(negedge clk);
    chk_reset("rst_issue");
    rst = 0;

    for (int i = 0; i < 150; i++) begin
      randomize_inputs();
      run($urandom_range(3));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", sc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
